// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: accepts a byte, then drives start, LSB-first data,
// optional parity and stop bits, each held for PRESCALE clocks, with back-to-back chaining.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 1
) (
  input  logic                  clk_ctrl,
  input  logic                  reset_ctrl,
  input  logic [DATA_WIDTH-1:0] p_data_ctrl,
  input  logic                  data_valid_ctrl,
  input  logic                  par_en_ctrl,
  input  logic                  par_typ_ctrl,
  output logic                  tx_out_ctrl,
  output logic                  busy_ctrl,
  output logic                  ser_en_ctrl,
  output logic [1:0]            mux_sel_ctrl,
  output logic                  par_load_ctrl
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  localparam logic [1:0] MUX_START  = 2'b00;
  localparam logic [1:0] MUX_DATA   = 2'b01;
  localparam logic [1:0] MUX_PARITY = 2'b10;
  localparam logic [1:0] MUX_STOP   = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state, state_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic [IDX_W-1:0]      idx, idx_nx;
  logic [DATA_WIDTH-1:0] data_lat, data_nx;
  logic                  par_en_lat, par_en_nx;
  logic                  par_typ_lat, par_typ_nx;
  logic                  last_cyc;
  logic                  accept;

  logic                  tx_nx;
  logic                  busy_nx;
  logic                  ser_en_nx;
  logic [1:0]            mux_nx;

  // Even parity is the plain XOR of the payload; odd parity is its complement.
  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic even);
    return even ? (^d) : (~^d);
  endfunction

  assign last_cyc = (cnt == CNT_LAST);
  assign accept   = data_valid_ctrl &&
                    ((state == IDLE) || ((state == STOP) && last_cyc));

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    data_nx    = data_lat;
    par_en_nx  = par_en_lat;
    par_typ_nx = par_typ_lat;
    cnt_nx     = (state == IDLE || last_cyc) ? '0 : cnt + 1'b1;

    unique case (state)
      IDLE: begin
        if (accept) state_nx = START;
      end
      START: begin
        if (last_cyc) begin
          state_nx = DATA;
          idx_nx   = '0;
        end
      end
      DATA: begin
        if (last_cyc) begin
          if (idx == IDX_LAST) state_nx = par_en_lat ? PARITY : STOP;
          else                 idx_nx   = idx + 1'b1;
        end
      end
      PARITY: begin
        if (last_cyc) state_nx = STOP;
      end
      STOP: begin
        if (last_cyc) state_nx = accept ? START : IDLE;
      end
      default: state_nx = IDLE;
    endcase

    if (accept) begin
      data_nx    = p_data_ctrl;
      par_en_nx  = par_en_ctrl;
      par_typ_nx = par_typ_ctrl;
      cnt_nx     = '0;
    end
  end

  // Output decode works on the next state so the registered outputs line up with it.
  always_comb begin
    tx_nx     = 1'b1;
    busy_nx   = 1'b1;
    ser_en_nx = 1'b0;
    mux_nx    = MUX_STOP;
    unique case (state_nx)
      IDLE: begin
        busy_nx = 1'b0;
      end
      START: begin
        tx_nx  = 1'b0;
        mux_nx = MUX_START;
      end
      DATA: begin
        tx_nx     = data_nx[idx_nx];
        ser_en_nx = 1'b1;
        mux_nx    = MUX_DATA;
      end
      PARITY: begin
        tx_nx  = parity_bit(data_nx, par_typ_nx);
        mux_nx = MUX_PARITY;
      end
      STOP: begin
        mux_nx = MUX_STOP;
      end
      default: begin
        busy_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_ctrl or negedge reset_ctrl) begin
    if (!reset_ctrl) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      data_lat      <= '0;
      par_en_lat    <= 1'b0;
      par_typ_lat   <= 1'b0;
      tx_out_ctrl   <= 1'b1;
      busy_ctrl     <= 1'b0;
      ser_en_ctrl   <= 1'b0;
      mux_sel_ctrl  <= MUX_STOP;
      par_load_ctrl <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      idx           <= idx_nx;
      data_lat      <= data_nx;
      par_en_lat    <= par_en_nx;
      par_typ_lat   <= par_typ_nx;
      tx_out_ctrl   <= tx_nx;
      busy_ctrl     <= busy_nx;
      ser_en_ctrl   <= ser_en_nx;
      mux_sel_ctrl  <= mux_nx;
      par_load_ctrl <= accept;
    end
  end

endmodule
